// File: rtl/fp_result_checker.sv
// fp_result_checker
// Receiving end of the fp_unit verification stream. Expected results are queued
// in issue order; each completion is paired with the oldest expectation, compared
// using the canonical-NaN rule, and tallied. The first mismatch is latched for
// post-mortem inspection.
module fp_result_checker #(
  parameter int DEPTH        = 8,     // power of two, >= 2
  parameter int CNT_W        = 32,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,        // asynchronous, active-low
  input  logic                    clear,
  input  logic                    exp_valid,
  output logic                    exp_ready,
  input  logic [31:0]             exp_result,
  input  logic [4:0]              exp_flags,
  input  logic                    exp_nanchk,
  input  logic                    res_valid,
  input  logic [31:0]             res_result,
  input  logic [4:0]              res_flags,
  output logic [$clog2(DEPTH):0]  pending,
  output logic [CNT_W-1:0]        pass_count,
  output logic [CNT_W-1:0]        fail_count,
  output logic                    fail_valid,
  output logic [31:0]             fail_exp,
  output logic [31:0]             fail_calc,
  output logic [4:0]              fail_fexp,
  output logic [4:0]              fail_fcalc,
  output logic                    underflow,
  output logic                    halted
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          PW        = AW + 1;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e state_q, state_d;

  // FIFO storage and bookkeeping
  logic [31:0]      mem_result [DEPTH];
  logic [4:0]       mem_flags  [DEPTH];
  logic             mem_nanchk [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_q,  count_d;

  // Holds exp_ready low while reset is asserted; rises on the first edge after release.
  logic             ready_q;

  // Statistics and first-failure record
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             fvalid_q, fvalid_d;
  logic [31:0]      fexp_q,   fexp_d;
  logic [31:0]      fcalc_q,  fcalc_d;
  logic [4:0]       ffexp_q,  ffexp_d;
  logic [4:0]       ffcalc_q, ffcalc_d;
  logic             uflow_q,  uflow_d;

  // Per-cycle events
  logic             running, full, empty;
  logic             push, take, pop, underflow_ev;
  logic             match_ev, mismatch_ev;

  // Head entry and comparison
  logic [31:0]      head_result;
  logic [4:0]       head_flags;
  logic             head_nanchk;
  logic             head_is_nan, res_ok, flg_ok, match;

  assign running   = (state_q == ST_RUN);
  assign full      = (count_q == PW'(DEPTH));
  assign empty     = (count_q == '0);

  // A full FIFO never accepts, even if a completion frees a slot in the same cycle.
  assign exp_ready = ready_q && running && !full;

  // clear takes priority: a push or completion presented alongside it is dropped.
  assign push         = exp_valid && exp_ready && !clear;
  assign take         = res_valid && running && !clear;
  assign underflow_ev = take && empty;
  assign pop          = take && !empty;
  assign match_ev     = pop && match;
  assign mismatch_ev  = pop && !match;

  assign head_result = mem_result[rd_ptr_q];
  assign head_flags  = mem_flags[rd_ptr_q];
  assign head_nanchk = mem_nanchk[rd_ptr_q];

  // Canonical-NaN compare: when the unit returns the canonical NaN for a float
  // result, any expected NaN (quiet or signalling payload) is accepted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    head_is_nan = (head_result[30:23] == 8'hFF) && (head_result[22:0] != '0);
    res_ok      = (head_result == res_result);
    if (head_nanchk && (res_result == CANON_NAN)) begin
      res_ok = head_is_nan;
    end
    flg_ok = (head_flags == res_flags);
    match  = res_ok && flg_ok;
  end

  // FSM next state: enter HALT on underflow or (optionally) on mismatch; only clear leaves it.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_RUN;
    end else if (running && (underflow_ev || (mismatch_ev && STOP_ON_FAIL))) begin
      state_d = ST_HALT;
    end
  end

  // Datapath next state: pointers, occupancy, saturating counters, first-failure capture.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    fvalid_d = fvalid_q;
    fexp_d   = fexp_q;
    fcalc_d  = fcalc_q;
    ffexp_d  = ffexp_q;
    ffcalc_d = ffcalc_q;
    uflow_d  = uflow_q;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      pass_d   = '0;
      fail_d   = '0;
      fvalid_d = 1'b0;
      fexp_d   = '0;
      fcalc_d  = '0;
      ffexp_d  = '0;
      ffcalc_d = '0;
      uflow_d  = 1'b0;
    end else begin
      // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (underflow_ev) uflow_d = 1'b1;

      if (match_ev && (pass_q != '1)) pass_d = pass_q + 1'b1;

      if (mismatch_ev) begin
        if (fail_q != '1) fail_d = fail_q + 1'b1;
        if (!fvalid_q) begin
          fvalid_d = 1'b1;
          fexp_d   = head_result;
          fcalc_d  = res_result;
          ffexp_d  = head_flags;
          ffcalc_d = res_flags;
        end
      end
    end
  end

  // State and control registers.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q  <= ST_RUN;
      ready_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      fvalid_q <= 1'b0;
      fexp_q   <= '0;
      fcalc_q  <= '0;
      ffexp_q  <= '0;
      ffcalc_q <= '0;
      uflow_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= 1'b1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      fvalid_q <= fvalid_d;
      fexp_q   <= fexp_d;
      fcalc_q  <= fcalc_d;
      ffexp_q  <= ffexp_d;
      ffcalc_q <= ffcalc_d;
      uflow_q  <= uflow_d;
    end
  end

  // Expectation storage write port.
  always_ff @(posedge clock) begin
    // NOTE: the storage array has no reset; occupancy tracking guarantees stale entries are never read.
    if (push) begin
      mem_result[wr_ptr_q] <= exp_result;
      mem_flags[wr_ptr_q]  <= exp_flags;
      mem_nanchk[wr_ptr_q] <= exp_nanchk;
    end
  end

  assign pending    = count_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign fail_valid = fvalid_q;
  assign fail_exp   = fexp_q;
  assign fail_calc  = fcalc_q;
  assign fail_fexp  = ffexp_q;
  assign fail_fcalc = ffcalc_q;
  assign underflow  = uflow_q;
  assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_fp_result_checker.sv
// Testbench for fp_result_checker. Two instances: unit 0 halts on the first
// mismatch (32-bit counters), unit 1 keeps checking (3-bit counters so that
// saturation is reachable). Each completion issued pushes its hand-computed
// outcome into a per-unit queue; a monitor pops it when the counters move.
module tb_fp_result_checker;

  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        clr [2];
  logic        ev  [2];
  logic        rdy [2];
  logic [31:0] er  [2];
  logic [4:0]  ef  [2];
  logic        en  [2];
  logic        rv  [2];
  logic [31:0] rr  [2];
  logic [4:0]  rf  [2];
  logic [PW-1:0] pend [2];
  logic        fv  [2];
  logic [31:0] fexp [2];
  logic [31:0] fcalc[2];
  logic [4:0]  ffexp[2];
  logic [4:0]  ffcalc[2];
  logic        uf  [2];
  logic        hlt [2];
  logic [31:0] pass0, fail0;
  logic [2:0]  pass1, fail1;

  int n_checks = 0;
  int n_errors = 0;
  bit sb0 [$];
  bit sb1 [$];

  fp_result_checker #(.DEPTH(DEPTH), .CNT_W(32), .STOP_ON_FAIL(1'b1)) u_stop (
    .clock(clk), .reset(rst_n), .clear(clr[0]),
    .exp_valid(ev[0]), .exp_ready(rdy[0]), .exp_result(er[0]), .exp_flags(ef[0]),
    .exp_nanchk(en[0]), .res_valid(rv[0]), .res_result(rr[0]), .res_flags(rf[0]),
    .pending(pend[0]), .pass_count(pass0), .fail_count(fail0), .fail_valid(fv[0]),
    .fail_exp(fexp[0]), .fail_calc(fcalc[0]), .fail_fexp(ffexp[0]), .fail_fcalc(ffcalc[0]),
    .underflow(uf[0]), .halted(hlt[0])
  );

  fp_result_checker #(.DEPTH(DEPTH), .CNT_W(3), .STOP_ON_FAIL(1'b0)) u_cont (
    .clock(clk), .reset(rst_n), .clear(clr[1]),
    .exp_valid(ev[1]), .exp_ready(rdy[1]), .exp_result(er[1]), .exp_flags(ef[1]),
    .exp_nanchk(en[1]), .res_valid(rv[1]), .res_result(rr[1]), .res_flags(rf[1]),
    .pending(pend[1]), .pass_count(pass1), .fail_count(fail1), .fail_valid(fv[1]),
    .fail_exp(fexp[1]), .fail_calc(fcalc[1]), .fail_fexp(ffexp[1]), .fail_fcalc(ffcalc[1]),
    .underflow(uf[1]), .halted(hlt[1])
  );

  function automatic logic [31:0] pc(int u);
    return (u == 0) ? pass0 : {29'b0, pass1};
  endfunction

  function automatic logic [31:0] fc(int u);
    return (u == 0) ? fail0 : {29'b0, fail1};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus on unit u; sb=1 records the hand-computed outcome of the completion.
  task automatic step(int u, bit e_v, logic [31:0] e_r, logic [4:0] e_f, bit e_n,
                      bit r_v, logic [31:0] r_r, logic [4:0] r_f, bit sb, bit pass);
    ev[u] = e_v; er[u] = e_r; ef[u] = e_f; en[u] = e_n;
    rv[u] = r_v; rr[u] = r_r; rf[u] = r_f;
    if (sb) begin
      if (u == 0) sb0.push_back(pass);
      else        sb1.push_back(pass);
    end
    @(posedge clk); #1;
    ev[u] = 1'b0;
    rv[u] = 1'b0;
  endtask

  task automatic push_e(int u, logic [31:0] r, logic [4:0] f, bit n);
    step(u, 1'b1, r, f, n, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
  endtask

  task automatic res_e(int u, logic [31:0] r, logic [4:0] f, bit pass);
    step(u, 1'b0, 32'h0, 5'h0, 1'b0, 1'b1, r, f, 1'b1, pass);
  endtask

  task automatic clear_u(int u);
    clr[u] = 1'b1;
    @(posedge clk); #1;
    clr[u] = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_all_zero(string tag);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s_u%0d_pending", tag, u), 32'(pend[u]), 32'd0);
      check($sformatf("%s_u%0d_pass", tag, u), pc(u), 32'd0);
      check($sformatf("%s_u%0d_fail", tag, u), fc(u), 32'd0);
      check($sformatf("%s_u%0d_status", tag, u),
            {28'd0, rdy[u], fv[u], uf[u], hlt[u]}, 32'd0);
      check($sformatf("%s_u%0d_fexp", tag, u), fexp[u] | fcalc[u], 32'd0);
      check($sformatf("%s_u%0d_fflags", tag, u), {22'd0, ffexp[u], ffcalc[u]}, 32'd0);
    end
  endtask

  // Monitor: each counter movement consumes one queued outcome.
  logic [31:0] prev_p [2] = '{32'd0, 32'd0};
  logic [31:0] prev_f [2] = '{32'd0, 32'd0};
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      automatic logic [31:0] p = pc(u);
      automatic logic [31:0] f = fc(u);
      automatic bit          exp_pass;
      automatic bit          have;
      if (p < prev_p[u] || f < prev_f[u]) begin
        // counters flushed by clear or reset
      end else if (p != prev_p[u] || f != prev_f[u]) begin
        have = (u == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
        if (!have) begin
          n_checks++;
          n_errors++;
          $display("FAIL u%0d_unexpected_completion: pass=%0d fail=%0d with nothing queued", u, p, f);
        end else begin
          exp_pass = (u == 0) ? sb0.pop_front() : sb1.pop_front();
          check($sformatf("u%0d_outcome(pass_delta,fail_delta)", u),
                {16'(p - prev_p[u]), 16'(f - prev_f[u])},
                exp_pass ? 32'h0001_0000 : 32'h0000_0001);
        end
      end
      prev_p[u] = p;
      prev_f[u] = f;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      clr[u] = 0; ev[u] = 0; er[u] = 0; ef[u] = 0; en[u] = 0;
      rv[u] = 0; rr[u] = 0; rf[u] = 0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all_zero("in_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready_u0", 32'(rdy[0]), 32'd1);
    check("post_reset_ready_u1", 32'(rdy[1]), 32'd1);

    // 1: single matching transaction
    push_e(0, 32'h3F80_0000, 5'h00, 1'b1);
    idle(1);
    res_e(0, 32'h3F80_0000, 5'h00, 1'b1);
    @(negedge clk);
    check("t1_pass", pc(0), 32'd1);
    check("t1_fail", fc(0), 32'd0);
    check("t1_pending", 32'(pend[0]), 32'd0);
    check("t1_halted", 32'(hlt[0]), 32'd0);

    // 2: canonical-NaN rule (unit 1 so the failing case does not halt)
    push_e(1, 32'h7FC0_0000, 5'h10, 1'b1);
    res_e(1, 32'h7FC0_0000, 5'h10, 1'b1);
    push_e(1, 32'h7F80_0001, 5'h10, 1'b1);
    res_e(1, 32'h7FC0_0000, 5'h10, 1'b1);
    push_e(1, 32'h7F80_0000, 5'h00, 1'b1);
    res_e(1, 32'h7FC0_0000, 5'h00, 1'b0);
    @(negedge clk);
    check("t2_pass", pc(1), 32'd2);
    check("t2_fail", fc(1), 32'd1);
    check("t2_fail_exp", fexp[1], 32'h7F80_0000);
    check("t2_fail_calc", fcalc[1], 32'h7FC0_0000);
    check("t2_halted", 32'(hlt[1]), 32'd0);
    clear_u(1);

    // 3: stop on fail, then clear
    clear_u(0);
    push_e(0, 32'h0000_0005, 5'h00, 1'b0);
    push_e(0, 32'h0000_0006, 5'h00, 1'b0);
    res_e(0, 32'h0000_0005, 5'h01, 1'b0);
    @(negedge clk);
    check("t3_fail_valid", 32'(fv[0]), 32'd1);
    check("t3_fail_fexp", 32'(ffexp[0]), 32'h00);
    check("t3_fail_fcalc", 32'(ffcalc[0]), 32'h01);
    check("t3_fail_exp", fexp[0], 32'h5);
    check("t3_fail_calc", fcalc[0], 32'h5);
    check("t3_halted", 32'(hlt[0]), 32'd1);
    check("t3_exp_ready", 32'(rdy[0]), 32'd0);
    check("t3_pending", 32'(pend[0]), 32'd1);
    step(0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b1, 32'h0000_0006, 5'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_ignored_pending", 32'(pend[0]), 32'd1);
    check("t3_ignored_counts", {pc(0)[15:0], fc(0)[15:0]}, 32'h0000_0001);
    clear_u(0);
    @(negedge clk);
    check("t3_clr_pending", 32'(pend[0]), 32'd0);
    check("t3_clr_counts", pc(0) | fc(0), 32'd0);
    check("t3_clr_status", {29'd0, hlt[0], fv[0], rdy[0]}, 32'd1);

    // 4: fill, full boundary, wrap-around
    for (int i = 0; i < 8; i++) push_e(0, 32'(i), 5'h00, 1'b0);
    @(negedge clk);
    check("t4_full_pending", 32'(pend[0]), 32'd8);
    check("t4_full_ready", 32'(rdy[0]), 32'd0);
    step(0, 1'b1, 32'h100, 5'h00, 1'b0, 1'b1, 32'h0, 5'h00, 1'b1, 1'b1);
    @(negedge clk);
    check("t4_drop_pending", 32'(pend[0]), 32'd7);
    for (int j = 0; j < 20; j++)
      step(0, 1'b1, 32'(8 + j), 5'h00, 1'b0, 1'b1, 32'(1 + j), 5'h00, 1'b1, 1'b1);
    @(negedge clk);
    check("t4_pass", pc(0), 32'd21);
    check("t4_fail", fc(0), 32'd0);
    check("t4_pending", 32'(pend[0]), 32'd7);
    clear_u(0);

    // 6: keep checking after fails; first failure record holds
    push_e(1, 32'h1111_1111, 5'h00, 1'b0);
    res_e(1, 32'h1111_1111, 5'h00, 1'b1);
    push_e(1, 32'h2222_2222, 5'h04, 1'b0);
    res_e(1, 32'h2222_2223, 5'h04, 1'b0);
    push_e(1, 32'h3F00_0000, 5'h01, 1'b1);
    res_e(1, 32'h3F00_0000, 5'h01, 1'b1);
    push_e(1, 32'h7F80_0000, 5'h00, 1'b1);
    res_e(1, 32'h7FC0_0000, 5'h00, 1'b0);
    @(negedge clk);
    check("t6_pass", pc(1), 32'd2);
    check("t6_fail", fc(1), 32'd2);
    check("t6_fail_exp", fexp[1], 32'h2222_2222);
    check("t6_fail_calc", fcalc[1], 32'h2222_2223);
    check("t6_fail_flags", {22'd0, ffexp[1], ffcalc[1]}, {22'd0, 5'h04, 5'h04});
    check("t6_halted", 32'(hlt[1]), 32'd0);

    // counter saturation on the 3-bit unit
    for (int k = 0; k < 6; k++) begin
      push_e(1, 32'(k + 40), 5'h00, 1'b0);
      step(1, 1'b0, 32'h0, 5'h0, 1'b0, 1'b1, 32'(k + 40), 5'h00, (k < 5), 1'b1);
    end
    @(negedge clk);
    check("sat_pass", pc(1), 32'd7);
    check("sat_fail", fc(1), 32'd2);
    check("sat_pending", 32'(pend[1]), 32'd0);
    clear_u(1);

    // 5: underflow, including a push into the empty FIFO in the same cycle
    step(1, 1'b0, 32'h0, 5'h0, 1'b0, 1'b1, 32'h0, 5'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_underflow", {30'd0, uf[1], hlt[1]}, 32'd3);
    check("t5_counts", pc(1) | fc(1), 32'd0);
    check("t5_ready", 32'(rdy[1]), 32'd0);
    clear_u(1);
    step(1, 1'b1, 32'hA, 5'h00, 1'b0, 1'b1, 32'hA, 5'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_push_uf_flags", {30'd0, uf[1], hlt[1]}, 32'd3);
    check("t5_push_uf_pending", 32'(pend[1]), 32'd1);
    check("t5_push_uf_counts", pc(1) | fc(1), 32'd0);
    clear_u(1);
    for (int i = 0; i < 3; i++) push_e(1, 32'(i), 5'h00, 1'b0);
    push_e(0, 32'h55, 5'h00, 1'b0);
    @(negedge clk);
    check("t5_pending3", 32'(pend[1]), 32'd3);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk) rst_n = 1'b1;
    idle(2);

    check("drain_u0", 32'(sb0.size()), 32'd0);
    check("drain_u1", 32'(sb1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
